// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_t;

   localparam int REQ_PROC        = 0;
   localparam int REQ_AUX         = 1;
   localparam int DEF_MEM_LATENCY = 2;

   function automatic logic [1:0] onehot2(input logic idx);
      return (idx == 1'(REQ_AUX)) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin picker: a lone requester wins outright,
// on a tie the favoured requester (ptr) wins.
module rr_pick2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       winner,
   output logic       valid
);

   assign valid  = |req;
   assign winner = (&req) ? ptr : req[REQ_AUX];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the processor and an auxiliary master,
// sequencing each access as a fixed-latency strobe then a DONE pulse.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 26,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [1:0]        REQ,
   input  logic [1:0]        WE,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA0,
   input  logic [DATA_W-1:0] WDATA1,
   output logic [1:0]        GNT,
   output logic [1:0]        DONE,
   output logic [DATA_W-1:0] RDATA,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_DATA_OUT,
   input  logic [DATA_W-1:0] MEM_DATA_IN
);

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   arb_state_t state, state_nxt;
   logic       ptr;
   logic       win;
   logic       op;
   logic [3:0] cnt;
   logic       pick_win;
   logic       pick_vld;

   rr_pick2 u_pick (
      .req    (REQ),
      .ptr    (ptr),
      .winner (pick_win),
      .valid  (pick_vld)
   );

   // state register; reset aborts any access in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= ARB_IDLE;
      else      state <= state_nxt;
   end

   // next-state: IDLE -> ACCESS -> RESP -> IDLE
   always_comb begin
      state_nxt = state;
      unique case (state)
         ARB_IDLE:   if (pick_vld) state_nxt = ARB_ACCESS;
         ARB_ACCESS: if (cnt == 4'd0) state_nxt = ARB_RESP;
         ARB_RESP:   state_nxt = ARB_IDLE;
         default:    state_nxt = ARB_IDLE;
      endcase
   end

   // latch winner operands, count strobe cycles, capture read data
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr          <= 1'b0;
         win          <= 1'b0;
         op           <= 1'b0;
         cnt          <= 4'd0;
         MEM_ADDR     <= '0;
         MEM_DATA_OUT <= '0;
         RDATA        <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (pick_vld) begin
                  win          <= pick_win;
                  op           <= WE[pick_win];
                  MEM_ADDR     <= pick_win ? ADDR1 : ADDR0;
                  MEM_DATA_OUT <= pick_win ? WDATA1 : WDATA0;
                  cnt          <= LAT_M1;
               end
            end
            ARB_ACCESS: begin
               if (cnt == 4'd0) begin
                  if (!op) RDATA <= MEM_DATA_IN;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ARB_RESP: ptr <= ~win;
            default: ;
         endcase
      end
   end

   assign GNT       = (state != ARB_IDLE) ? onehot2(win) : 2'b00;
   assign DONE      = (state == ARB_RESP) ? onehot2(win) : 2'b00;
   assign MEM_READ  = (state == ARB_ACCESS) && !op;
   assign MEM_WRITE = (state == ARB_ACCESS) && op;

endmodule
